// File: rtl/cpu_instr_sequencer_pkg.sv
// cpu_instr_sequencer_pkg
// Shared definitions for the PIC10-compatible Q-phase sequencer:
// Q-phase and FSM state encodings, and opcode match masks/values
// for the 12-bit baseline instruction set.
package cpu_instr_sequencer_pkg;

    // Q-phase encoding, 0..3 = Q1..Q4
    typedef enum logic [1:0] {
        PH_Q1 = 2'd0,
        PH_Q2 = 2'd1,
        PH_Q3 = 2'd2,
        PH_Q4 = 2'd3
    } qphase_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_EXEC  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_SLEEP = 2'd2
    } seq_state_t;

    // Opcode match masks and values (instr & MASK) == VAL
    localparam logic [11:0] OP_SLEEP_M  = 12'hFFF;
    localparam logic [11:0] OP_SLEEP_V  = 12'h003;
    localparam logic [11:0] OP_MOVWF_M  = 12'hFE0;
    localparam logic [11:0] OP_MOVWF_V  = 12'h020;
    localparam logic [11:0] OP_CLRW_M   = 12'hFFF;
    localparam logic [11:0] OP_CLRW_V   = 12'h040;
    localparam logic [11:0] OP_CLRF_M   = 12'hFE0;
    localparam logic [11:0] OP_CLRF_V   = 12'h060;
    localparam logic [11:0] OP_DECFSZ_M = 12'hFC0;
    localparam logic [11:0] OP_DECFSZ_V = 12'h2C0;
    localparam logic [11:0] OP_INCFSZ_M = 12'hFC0;
    localparam logic [11:0] OP_INCFSZ_V = 12'h3C0;
    localparam logic [11:0] OP_BCF_M    = 12'hF00;
    localparam logic [11:0] OP_BCF_V    = 12'h400;
    localparam logic [11:0] OP_BSF_M    = 12'hF00;
    localparam logic [11:0] OP_BSF_V    = 12'h500;
    localparam logic [11:0] OP_BTFSC_M  = 12'hF00;
    localparam logic [11:0] OP_BTFSC_V  = 12'h600;
    localparam logic [11:0] OP_BTFSS_M  = 12'hF00;
    localparam logic [11:0] OP_BTFSS_V  = 12'h700;
    localparam logic [11:0] OP_RETLW_M  = 12'hF00;
    localparam logic [11:0] OP_RETLW_V  = 12'h800;
    localparam logic [11:0] OP_CALL_M   = 12'hF00;
    localparam logic [11:0] OP_CALL_V   = 12'h900;
    localparam logic [11:0] OP_GOTO_M   = 12'hE00;
    localparam logic [11:0] OP_GOTO_V   = 12'hA00;
    // MOVLW/IORLW/ANDLW/XORLW all live in 11xx_xxxx_xxxx
    localparam logic [11:0] OP_LITALU_M = 12'hC00;
    localparam logic [11:0] OP_LITALU_V = 12'hC00;

    // True when the instruction word matches a mask/value pair
    function automatic logic op_match(input logic [11:0] instr,
                                      input logic [11:0] mask,
                                      input logic [11:0] val);
        return (instr & mask) == val;
    endfunction

    // Byte-oriented ops carrying a d bit (SUBWF 0x080 .. INCFSZ 0x3FF)
    function automatic logic is_byte_dop(input logic [11:0] instr);
        return (instr[11:10] == 2'b00) && (instr[9:7] != 3'b000);
    endfunction

    // Q counter advance with Q4 -> Q1 wrap
    function automatic qphase_t next_phase(input qphase_t ph);
        qphase_t nxt;
        case (ph)
            PH_Q1:   nxt = PH_Q2;
            PH_Q2:   nxt = PH_Q3;
            PH_Q3:   nxt = PH_Q4;
            default: nxt = PH_Q1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cpu_instr_sequencer_decoder.sv
// cpu_instr_decoder
// Purely combinational decode of the instruction register into the
// class flags the sequencer needs to build its Q4 strobes.
module cpu_instr_decoder
    import cpu_instr_sequencer_pkg::*;
(
    input  logic [11:0] instr,
    output logic        writes_w,
    output logic        writes_f,
    output logic        is_skip_z,
    output logic        is_btfsc,
    output logic        is_btfss,
    output logic        is_goto,
    output logic        is_call,
    output logic        is_retlw,
    output logic        is_sleep,
    output logic        uses_file
);

    logic w_byte_dop;
    logic w_dest_f;
    logic w_movwf;
    logic w_clrw;
    logic w_clrf;
    logic w_bit_op;
    logic w_bcf_bsf;
    logic w_lit_alu;

    assign w_byte_dop = is_byte_dop(instr);
    assign w_dest_f   = instr[5];
    assign w_movwf    = op_match(instr, OP_MOVWF_M, OP_MOVWF_V);
    assign w_clrw     = op_match(instr, OP_CLRW_M,  OP_CLRW_V);
    assign w_clrf     = op_match(instr, OP_CLRF_M,  OP_CLRF_V);
    assign w_bit_op   = (instr[11:10] == 2'b01);
    assign w_bcf_bsf  = op_match(instr, OP_BCF_M, OP_BCF_V)
                      | op_match(instr, OP_BSF_M, OP_BSF_V);
    assign w_lit_alu  = op_match(instr, OP_LITALU_M, OP_LITALU_V);

    // Class flags; anything not matched here falls through as a NOP
    always_comb begin
        is_goto   = op_match(instr, OP_GOTO_M,  OP_GOTO_V);
        is_call   = op_match(instr, OP_CALL_M,  OP_CALL_V);
        is_retlw  = op_match(instr, OP_RETLW_M, OP_RETLW_V);
        is_btfsc  = op_match(instr, OP_BTFSC_M, OP_BTFSC_V);
        is_btfss  = op_match(instr, OP_BTFSS_M, OP_BTFSS_V);
        is_sleep  = op_match(instr, OP_SLEEP_M, OP_SLEEP_V);
        is_skip_z = op_match(instr, OP_DECFSZ_M, OP_DECFSZ_V)
                  | op_match(instr, OP_INCFSZ_M, OP_INCFSZ_V);
        writes_w  = (w_byte_dop & ~w_dest_f) | w_clrw | w_lit_alu | is_retlw;
        writes_f  = (w_byte_dop &  w_dest_f) | w_movwf | w_clrf | w_bcf_bsf;
        uses_file = w_byte_dop | w_movwf | w_clrf | w_bit_op;
    end

endmodule

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer
// Q1..Q4 phase sequencer and control unit for the PIC10-compatible core.
// Holds the instruction register, issues the Q4 datapath/PC/stack strobes
// and inserts forced-NOP flush slots after branches and taken skips.
// Optional SLEEP support is enabled by defining CPU_SLEEP_EN.
module cpu_instr_sequencer
    import cpu_instr_sequencer_pkg::*;
#(
    parameter logic [4:0]  SFR_TOP  = 5'd7,
    parameter logic [11:0] NOP_WORD = 12'h000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        run_en,
    input  logic [11:0] instr_in,
    input  logic        alu_zero_in,
    input  logic        wake_in,
    output logic [11:0] instruction_out,
    output logic [1:0]  q_phase,
    output logic        alu_in_select,
    output logic        store_alu_w,
    output logic        reg_write_en,
    output logic        status_commit,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        stack_push,
    output logic        stack_pop,
    output logic        sleeping
);

    qphase_t    r_phase;
    seq_state_t r_state;
    logic       r_flush_skip;
    logic [11:0] r_ir;

    qphase_t    w_phase_nxt;
    seq_state_t w_state_nxt;
    logic       w_flush_skip_nxt;
    logic [11:0] w_ir_nxt;

    logic w_writes_w;
    logic w_writes_f;
    logic w_is_skip_z;
    logic w_is_btfsc;
    logic w_is_btfss;
    logic w_is_goto;
    logic w_is_call;
    logic w_is_retlw;
    logic w_is_sleep;
    logic w_uses_file;
    logic w_branch;
    logic w_skip_taken;
    logic w_sleep_take;
    logic w_wake;

    cpu_instr_decoder u_decoder (
        .instr     (r_ir),
        .writes_w  (w_writes_w),
        .writes_f  (w_writes_f),
        .is_skip_z (w_is_skip_z),
        .is_btfsc  (w_is_btfsc),
        .is_btfss  (w_is_btfss),
        .is_goto   (w_is_goto),
        .is_call   (w_is_call),
        .is_retlw  (w_is_retlw),
        .is_sleep  (w_is_sleep),
        .uses_file (w_uses_file)
    );

    assign w_branch     = w_is_goto | w_is_call | w_is_retlw;
    assign w_skip_taken = (w_is_skip_z & alu_zero_in)
                        | (w_is_btfsc  & alu_zero_in)
                        | (w_is_btfss  & ~alu_zero_in);

`ifdef CPU_SLEEP_EN
    assign w_sleep_take = w_is_sleep;
    assign w_wake       = wake_in;
    assign sleeping     = (r_state == ST_SLEEP);
`else
    logic w_unused_sleep;
    assign w_sleep_take   = 1'b0;
    assign w_wake         = 1'b0;
    assign sleeping       = 1'b0;
    assign w_unused_sleep = w_is_sleep | wake_in;
`endif

    assign instruction_out = r_ir;
    assign q_phase         = r_phase;

    // Phase/state/IR registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase      <= PH_Q1;
            r_state      <= ST_EXEC;
            r_flush_skip <= 1'b0;
            r_ir         <= NOP_WORD;
        end else begin
            r_phase      <= w_phase_nxt;
            r_state      <= w_state_nxt;
            r_flush_skip <= w_flush_skip_nxt;
            r_ir         <= w_ir_nxt;
        end
    end

    // Next-state and strobe decode; run_en low freezes state and kills strobes
    always_comb begin
        w_phase_nxt      = r_phase;
        w_state_nxt      = r_state;
        w_flush_skip_nxt = r_flush_skip;
        w_ir_nxt         = r_ir;
        store_alu_w      = 1'b0;
        reg_write_en     = 1'b0;
        status_commit    = 1'b0;
        pc_inc           = 1'b0;
        pc_load          = 1'b0;
        stack_push       = 1'b0;
        stack_pop        = 1'b0;
        alu_in_select    = (r_phase != PH_Q1) && w_uses_file && (r_ir[4:0] <= SFR_TOP);

        if (run_en) begin
            case (r_state)
                ST_EXEC: begin
                    w_phase_nxt = next_phase(r_phase);
                    if (r_phase == PH_Q1) begin
                        w_ir_nxt = instr_in;
                    end
                    if (r_phase == PH_Q4) begin
                        status_commit = 1'b1;
                        store_alu_w   = w_writes_w;
                        reg_write_en  = w_writes_f;
                        pc_load       = w_branch;
                        pc_inc        = ~w_branch;
                        stack_push    = w_is_call;
                        stack_pop     = w_is_retlw;
                        if (w_branch) begin
                            w_state_nxt      = ST_FLUSH;
                            w_flush_skip_nxt = 1'b0;
                        end else if (w_skip_taken) begin
                            w_state_nxt      = ST_FLUSH;
                            w_flush_skip_nxt = 1'b1;
                        end else if (w_sleep_take) begin
                            w_state_nxt = ST_SLEEP;
                        end
                    end
                end
                ST_FLUSH: begin
                    w_phase_nxt = next_phase(r_phase);
                    if (r_phase == PH_Q1) begin
                        w_ir_nxt = NOP_WORD;
                    end
                    if (r_phase == PH_Q4) begin
                        pc_inc           = r_flush_skip;
                        w_state_nxt      = ST_EXEC;
                        w_flush_skip_nxt = 1'b0;
                    end
                end
                ST_SLEEP: begin
                    w_phase_nxt = PH_Q1;
                    if (w_wake) begin
                        w_state_nxt = ST_EXEC;
                    end
                end
                default: begin
                    w_phase_nxt = PH_Q1;
                    w_state_nxt = ST_EXEC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb_cpu_instr_sequencer
// Directed scoreboard bench: the stimulus process drives one clock at a
// time and queues the hand-derived output set for that clock; a monitor
// pops and compares on every falling edge.
module tb_cpu_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        runEn;
    logic [11:0] instrIn;
    logic        zeroIn;
    logic        wakeIn;
    logic [11:0] instructionOut;
    logic [1:0]  qPhase;
    logic        aluInSelect;
    logic        storeAluW;
    logic        regWriteEn;
    logic        statusCommit;
    logic        pcInc;
    logic        pcLoad;
    logic        stackPush;
    logic        stackPop;
    logic        sleepingOut;

    cpu_instr_sequencer #(
        .SFR_TOP  (5'd7),
        .NOP_WORD (12'h000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run_en          (runEn),
        .instr_in        (instrIn),
        .alu_zero_in     (zeroIn),
        .wake_in         (wakeIn),
        .instruction_out (instructionOut),
        .q_phase         (qPhase),
        .alu_in_select   (aluInSelect),
        .store_alu_w     (storeAluW),
        .reg_write_en    (regWriteEn),
        .status_commit   (statusCommit),
        .pc_inc          (pcInc),
        .pc_load         (pcLoad),
        .stack_push      (stackPush),
        .stack_pop       (stackPop),
        .sleeping        (sleepingOut)
    );

    // Strobe vector order: {W, F, commit, inc, load, push, pop}
    localparam logic [6:0] S_NONE   = 7'b0000000;
    localparam logic [6:0] S_INC    = 7'b0001000;
    localparam logic [6:0] S_NOP    = 7'b0011000;
    localparam logic [6:0] S_WRW    = 7'b1011000;
    localparam logic [6:0] S_WRF    = 7'b0111000;
    localparam logic [6:0] S_GOTO   = 7'b0010100;
    localparam logic [6:0] S_CALL   = 7'b0010110;
    localparam logic [6:0] S_RETLW  = 7'b1010101;

    typedef struct packed {
        logic [1:0]  ph;
        logic [11:0] ir;
        logic        sel;
        logic        chkSel;
        logic [6:0]  str;
        logic        slp;
    } exp_t;

    exp_t        expQ[$];
    string       nameQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] prevIr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] ph, input logic [11:0] ir,
                                input logic sel, input logic chkSel,
                                input logic [6:0] str, input logic slp);
        exp_t e;
        e.ph = ph; e.ir = ir; e.sel = sel; e.chkSel = chkSel; e.str = str; e.slp = slp;
        return e;
    endfunction

    // One clock of stimulus plus the outputs expected during that clock
    task automatic driveCycle(input string nm, input logic r, input logic run,
                              input logic z, input logic w, input logic [11:0] ins,
                              input exp_t e);
        @(posedge clk);
        #1;
        rst = r; runEn = run; zeroIn = z; wakeIn = w; instrIn = ins;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    // One instruction slot, plus its flush slot when one is expected
    task automatic applyStimulus(input string nm, input logic [11:0] instr,
                                 input logic zero, input logic sel,
                                 input logic [6:0] q4, input logic flush,
                                 input logic flushInc);
        driveCycle(nm, 1'b1, 1'b1, 1'b0, 1'b0, instr,   mk(2'd0, prevIr, 1'b0, 1'b1, S_NONE, 1'b0));
        driveCycle(nm, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, mk(2'd1, instr, sel, 1'b1, S_NONE, 1'b0));
        driveCycle(nm, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, mk(2'd2, instr, sel, 1'b1, S_NONE, 1'b0));
        driveCycle(nm, 1'b1, 1'b1, zero, 1'b0, 12'hFFF, mk(2'd3, instr, sel, 1'b1, q4, 1'b0));
        prevIr = instr;
        if (flush) begin
            // INCFSZ with zero=1 sits in the flushed slot and must not skip again
            driveCycle({nm, "/flush"}, 1'b1, 1'b1, 1'b1, 1'b0, 12'h3E8, mk(2'd0, instr,   1'b0, 1'b1, S_NONE, 1'b0));
            driveCycle({nm, "/flush"}, 1'b1, 1'b1, 1'b1, 1'b0, 12'h3E8, mk(2'd1, 12'h000, 1'b0, 1'b1, S_NONE, 1'b0));
            driveCycle({nm, "/flush"}, 1'b1, 1'b1, 1'b1, 1'b0, 12'h3E8, mk(2'd2, 12'h000, 1'b0, 1'b1, S_NONE, 1'b0));
            driveCycle({nm, "/flush"}, 1'b1, 1'b1, 1'b1, 1'b0, 12'h3E8,
                       mk(2'd3, 12'h000, 1'b0, 1'b1, flushInc ? S_INC : S_NONE, 1'b0));
            prevIr = 12'h000;
        end
    endtask

    // Compare one queued expectation against the live DUT outputs
    task automatic checkOutput(input string nm, input exp_t e);
        logic [6:0] str;
        str = {storeAluW, regWriteEn, statusCommit, pcInc, pcLoad, stackPush, stackPop};
        vectors++;
        if (qPhase !== e.ph || instructionOut !== e.ir || str !== e.str ||
            sleepingOut !== e.slp || (e.chkSel && aluInSelect !== e.sel)) begin
            miscompares++;
            $display("[TB] FAIL %s: got ph=%0d ir=%h sel=%b str=%b slp=%b, want ph=%0d ir=%h sel=%b str=%b slp=%b",
                     nm, qPhase, instructionOut, aluInSelect, str, sleepingOut,
                     e.ph, e.ir, e.sel, e.str, e.slp);
        end
    endtask

    // Monitor: one comparison per clock that has a queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                exp_t  e;
                string nm;
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                checkOutput(nm, e);
            end
        end
    end

    // Directed stimulus
    initial begin
        rst = 1'b0; runEn = 1'b1; zeroIn = 1'b0; wakeIn = 1'b0; instrIn = 12'h000;
        prevIr = 12'h000;

        driveCycle("reset", 1'b0, 1'b1, 1'b0, 1'b0, 12'h1DF, mk(2'd0, 12'h000, 1'b0, 1'b1, S_NONE, 1'b0));
        driveCycle("reset", 1'b0, 1'b1, 1'b0, 1'b0, 12'h1DF, mk(2'd0, 12'h000, 1'b0, 1'b1, S_NONE, 1'b0));

        applyStimulus("addwf_1f_w",   12'h1DF, 1'b0, 1'b0, S_WRW,   1'b0, 1'b0);
        applyStimulus("movwf_03",     12'h023, 1'b0, 1'b1, S_WRF,   1'b0, 1'b0);
        applyStimulus("subwf_07_f",   12'h0A7, 1'b0, 1'b1, S_WRF,   1'b0, 1'b0);
        applyStimulus("subwf_08_w",   12'h088, 1'b0, 1'b0, S_WRW,   1'b0, 1'b0);
        applyStimulus("goto_10",      12'hA10, 1'b0, 1'b0, S_GOTO,  1'b1, 1'b0);
        applyStimulus("decfsz_z1",    12'h2F0, 1'b1, 1'b0, S_WRF,   1'b1, 1'b1);
        applyStimulus("decfsz_z0",    12'h2F0, 1'b0, 1'b0, S_WRF,   1'b0, 1'b0);
        applyStimulus("call_05",      12'h905, 1'b0, 1'b0, S_CALL,  1'b1, 1'b0);
        applyStimulus("retlw_aa",     12'h8AA, 1'b0, 1'b0, S_RETLW, 1'b1, 1'b0);
        applyStimulus("btfsc_z1",     12'h623, 1'b1, 1'b1, S_NOP,   1'b1, 1'b1);
        applyStimulus("btfsc_z0",     12'h623, 1'b0, 1'b1, S_NOP,   1'b0, 1'b0);
        applyStimulus("btfss_z0",     12'h723, 1'b0, 1'b1, S_NOP,   1'b1, 1'b1);
        applyStimulus("btfss_z1",     12'h723, 1'b1, 1'b1, S_NOP,   1'b0, 1'b0);
        applyStimulus("incfsz_z1",    12'h3E8, 1'b1, 1'b0, S_WRF,   1'b1, 1'b1);
        applyStimulus("movlw_55",     12'hC55, 1'b0, 1'b0, S_WRW,   1'b0, 1'b0);
        applyStimulus("bsf_05_7",     12'h5E5, 1'b0, 1'b1, S_WRF,   1'b0, 1'b0);
        applyStimulus("clrw",         12'h040, 1'b0, 1'b0, S_WRW,   1'b0, 1'b0);
        applyStimulus("clrf_07",      12'h067, 1'b0, 1'b1, S_WRF,   1'b0, 1'b0);
        applyStimulus("undef_041",    12'h041, 1'b0, 1'b0, S_NOP,   1'b0, 1'b0);
        applyStimulus("movf_1f_w",    12'h21F, 1'b0, 1'b0, S_WRW,   1'b0, 1'b0);

        // run_en dropped for 5 clocks at Q3, then for 2 clocks at Q4
        driveCycle("run_hold", 1'b1, 1'b1, 1'b0, 1'b0, 12'h023, mk(2'd0, prevIr, 1'b0, 1'b1, S_NONE, 1'b0));
        driveCycle("run_hold", 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, mk(2'd1, 12'h023, 1'b1, 1'b1, S_NONE, 1'b0));
        for (int i = 0; i < 5; i++)
            driveCycle("run_hold_q3", 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, mk(2'd2, 12'h023, 1'b1, 1'b0, S_NONE, 1'b0));
        driveCycle("run_hold", 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, mk(2'd2, 12'h023, 1'b1, 1'b1, S_NONE, 1'b0));
        for (int i = 0; i < 2; i++)
            driveCycle("run_hold_q4", 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, mk(2'd3, 12'h023, 1'b1, 1'b0, S_NONE, 1'b0));
        driveCycle("run_resume_q4", 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, mk(2'd3, 12'h023, 1'b1, 1'b1, S_WRF, 1'b0));
        prevIr = 12'h023;

`ifdef CPU_SLEEP_EN
        applyStimulus("sleep", 12'h003, 1'b0, 1'b0, S_NOP, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            driveCycle("sleep_hold", 1'b1, 1'b1, 1'b0, 1'b0, 12'h1DF, mk(2'd0, 12'h003, 1'b0, 1'b1, S_NONE, 1'b1));
        driveCycle("wake_gated", 1'b1, 1'b0, 1'b0, 1'b1, 12'h1DF, mk(2'd0, 12'h003, 1'b0, 1'b0, S_NONE, 1'b1));
        driveCycle("wake",       1'b1, 1'b1, 1'b0, 1'b1, 12'h1DF, mk(2'd0, 12'h003, 1'b0, 1'b1, S_NONE, 1'b1));
        applyStimulus("after_wake", 12'h1DF, 1'b0, 1'b0, S_WRW, 1'b0, 1'b0);
`else
        applyStimulus("sleep_as_nop", 12'h003, 1'b0, 1'b0, S_NOP, 1'b0, 1'b0);
`endif

        // Reset asserted during Q3 of ADDWF
        driveCycle("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0, 12'h1DF, mk(2'd0, prevIr, 1'b0, 1'b1, S_NONE, 1'b0));
        driveCycle("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, mk(2'd1, 12'h1DF, 1'b0, 1'b1, S_NONE, 1'b0));
        driveCycle("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, mk(2'd0, 12'h000, 1'b0, 1'b1, S_NONE, 1'b0));
        driveCycle("rst_mid", 1'b0, 1'b1, 1'b1, 1'b0, 12'hFFF, mk(2'd0, 12'h000, 1'b0, 1'b1, S_NONE, 1'b0));
        prevIr = 12'h000;
        applyStimulus("after_rst", 12'h1DF, 1'b0, 1'b0, S_WRW, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
